// File: rtl/fifo_rd_ctl.sv
// Read-side controller for the lifting FIFO: pops words into a 2-entry
// skid buffer and presents them as a valid/ready stream with row markers.
module fifo_rd_ctl #(
  parameter int DW    = 15,
  parameter int FRAME = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          empty_r,
  output logic          enr_r,
  input  logic [DW-1:0] dataout_r,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int IW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME - 1);

  logic [DW-1:0] b0_q, b0_d;
  logic [DW-1:0] b1_q, b1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          infl_q;
  logic [IW-1:0] idx_q, idx_d;

  logic       pop;
  logic [1:0] occ;
  logic [1:0] left;

  assign pop  = (cnt_q != 2'd0) && out_ready;
  assign occ  = cnt_q + {1'b0, infl_q};
  assign left = cnt_q - {1'b0, pop};

  // A head leaving this cycle frees its slot, so full rate needs no 3rd entry
  assign enr_r = !rst && !empty_r && !flush
              && ((occ - {1'b0, pop}) < 2'd2);

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = b0_q;
  assign out_last  = out_valid && (idx_q == LAST);

  always_comb begin
    b0_d  = b0_q;
    b1_d  = b1_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (flush) begin
      cnt_d = 2'd0;
      idx_d = '0;
    end else begin
      if (pop) begin
        b0_d  = b1_q;
        idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
      end
      if (infl_q) begin
        if (left == 2'd0) b0_d = dataout_r;
        else              b1_d = dataout_r;
        cnt_d = left + 2'd1;
      end else begin
        cnt_d = left;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_q   <= '0;
      b1_q   <= '0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      b0_q   <= b0_d;
      b1_q   <= b1_d;
      cnt_q  <= cnt_d;
      infl_q <= enr_r;
      idx_q  <= idx_d;
    end
  end

endmodule
